// File: rtl/cla_pkg.sv
// Shared constants and the lookahead helper used by every adder segment.
package cla_pkg;

  localparam int unsigned CLA_WIDTH  = 16;
  localparam int unsigned CLA_STAGES = 4;
  localparam int unsigned CLA_GROUP  = 4;
  localparam int unsigned MAX_GROUP  = 8;

  typedef struct packed {
    logic [MAX_GROUP:0] c;
    logic               gg;
    logic               pg;
  } la_t;

  // Sum-of-products lookahead over the low n bits: c[i] never depends on c[i-1].
  function automatic la_t lookahead(input logic [MAX_GROUP-1:0] g,
                                    input logic [MAX_GROUP-1:0] p,
                                    input logic                 ci,
                                    input int unsigned          n);
    la_t  r;
    logic term;
    r      = '0;
    r.c[0] = ci;
    for (int unsigned i = 1; i <= MAX_GROUP; i++) begin
      if (i <= n) begin
        term = ci;
        for (int unsigned j = 0; j < MAX_GROUP; j++)
          if (j < i) term &= p[j];
        r.c[i] = term;
        for (int unsigned j = 0; j < MAX_GROUP; j++) begin
          if (j < i) begin
            term = g[j];
            for (int unsigned m = 0; m < MAX_GROUP; m++)
              if (m > j && m < i) term &= p[m];
            r.c[i] |= term;
          end
        end
      end
    end
    r.pg = 1'b1;
    for (int unsigned j = 0; j < MAX_GROUP; j++) begin
      if (j < n) begin
        r.pg &= p[j];
        term = g[j];
        for (int unsigned m = 0; m < MAX_GROUP; m++)
          if (m > j && m < n) term &= p[m];
        r.gg |= term;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
interface pipelined_cla_adder_if #(
  parameter int unsigned WIDTH = cla_pkg::CLA_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_segment.sv
// Combinational SEG-bit two-level carry-lookahead adder (bit groups, then group G/P).
module cla_segment
  import cla_pkg::*;
#(
  parameter int unsigned SEG   = 4,
  parameter int unsigned GROUP = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);
  localparam int unsigned NG = SEG / GROUP;

  logic [SEG-1:0]       g;
  logic [SEG-1:0]       p;
  logic [SEG:0]         c;
  logic [MAX_GROUP-1:0] gg_v;
  logic [MAX_GROUP-1:0] pg_v;
  la_t                  gl;
  la_t                  bl;
  la_t                  grp;
  logic                 unused_la;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg_v      = '0;
    pg_v      = '0;
    c         = '0;
    gl        = '0;
    bl        = '0;
    unused_la = 1'b0;
    for (int unsigned j = 0; j < NG; j++) begin
      gl = lookahead(MAX_GROUP'(g[j*GROUP +: GROUP]), MAX_GROUP'(p[j*GROUP +: GROUP]), 1'b0, GROUP);
      gg_v[j]    = gl.gg;
      pg_v[j]    = gl.pg;
      unused_la ^= ^gl.c;
    end
    grp = lookahead(gg_v, pg_v, ci, NG);
    // Group carries come from the second lookahead level, then feed each group's own lookahead.
    for (int unsigned j = 0; j < NG; j++) begin
      bl = lookahead(MAX_GROUP'(g[j*GROUP +: GROUP]), MAX_GROUP'(p[j*GROUP +: GROUP]), grp.c[j], GROUP);
      for (int unsigned i = 0; i < GROUP; i++)
        c[j*GROUP + i] = bl.c[i];
      unused_la ^= ^{bl.gg, bl.pg, bl.c[MAX_GROUP:GROUP]};
    end
    c[SEG]     = grp.gg | (grp.pg & ci);
    unused_la ^= ^grp.c;
  end

  assign s     = p ^ c[SEG-1:0];
  assign co    = c[SEG];
  assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: one SEG-bit segment per stage, valid/ready backpressure, flags.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = CLA_WIDTH,
  parameter int unsigned STAGES = CLA_STAGES,
  parameter int unsigned GROUP  = CLA_GROUP
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_cla_adder_if.slave bus
);
  localparam int unsigned SEG = WIDTH / STAGES;

  logic [WIDTH-1:0]  a_r   [STAGES];
  logic [WIDTH-1:0]  b_r   [STAGES];
  logic [WIDTH-1:0]  s_r   [STAGES];
  logic              c_r   [STAGES];
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic              out_adv;
  logic              bubble;

  logic [SEG-1:0]    seg_s  [STAGES];
  logic              seg_co [STAGES];
  logic              seg_cm [STAGES];
  logic [WIDTH-1:0]  nxt_s  [STAGES];

  logic              out_v;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;
  logic              zero_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cla_segment #(.SEG(SEG), .GROUP(GROUP)) u_seg (
      .a     (a_r[k][k*SEG +: SEG]),
      .b     (b_r[k][k*SEG +: SEG]),
      .ci    (c_r[k]),
      .s     (seg_s[k]),
      .co    (seg_co[k]),
      .c_msb (seg_cm[k])
    );
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      nxt_s[k]                = s_r[k];
      nxt_s[k][k*SEG +: SEG]  = seg_s[k];
    end
  end

  // A stage may move if any stage at or after it has a hole, or the output drains.
  always_comb begin
    out_adv = !out_v || bus.out_ready;
    bubble  = out_adv;
    adv     = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      bubble                = bubble || !v[STAGES-1-i];
      adv[STAGES-1-i]       = bubble;
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = out_v;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v      <= '0;
      out_v  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
        c_r[k] <= 1'b0;
      end
    end else begin
      if (adv[0]) begin
        v[0] <= bus.in_valid;
        if (bus.in_valid) begin
          a_r[0] <= bus.a;
          b_r[0] <= bus.sub ? ~bus.b : bus.b;
          s_r[0] <= '0;
          c_r[0] <= bus.sub | bus.cin;
        end
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) begin
            a_r[k] <= a_r[k-1];
            b_r[k] <= b_r[k-1];
            s_r[k] <= nxt_s[k-1];
            c_r[k] <= seg_co[k-1];
          end
        end
      end
      if (out_adv) begin
        out_v <= v[STAGES-1];
        if (v[STAGES-1]) begin
          sum_q  <= nxt_s[STAGES-1];
          cout_q <= seg_co[STAGES-1];
          ovf_q  <= seg_co[STAGES-1] ^ seg_cm[STAGES-1];
          zero_q <= ~|nxt_s[STAGES-1];
        end
      end
    end
  end

endmodule
